row_seq_feeder: RTL

- Upstream stage of the 10-way row selector mux in the systolic-array datapath.
- Buffers up to DEPTH rows written over a valid/ready port, then presents all banks in parallel alongside a stepping select index and valid flag.
- The mux downstream picks one row per beat.
- While idle, the select output parks at an out-of-range code so the downstream mux outputs zero.

---
 rtl/row_seq_feeder_if.sv | 45 ++++
 rtl/row_seq_feeder.sv | 99 +++++++++
 2 files changed

// File: rtl/row_seq_feeder_if.sv
// Handshake and bus bundle between the row feeder and its neighbours.
// The i_loop field exists only when ROW_SEQ_LOOP_EN is defined.
interface row_seq_feeder_if #(
   parameter int ROW   = 9,
   parameter int DEPTH = 10,
   parameter int SEL_W = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   // Both ports use valid/ready. A beat transfers on a cycle where valid and
   // ready are both high. The sender holds its data steady until that happens.
   logic                 i_wr_valid;
   logic [ROW-1:0]       i_wr_data;
   logic                 i_wr_last;
   logic                 o_wr_ready;
   logic                 i_start;
   logic [ROW*DEPTH-1:0] o_rows;
   logic [SEL_W-1:0]     o_sel;
   logic                 o_valid;
   logic                 i_ready;
   logic                 o_done;
   logic [CNT_W-1:0]     o_count;
   logic                 o_busy;
   logic [1:0]           dbg_state;
`ifdef ROW_SEQ_LOOP_EN
   logic                 i_loop;

   modport master (
      output i_wr_valid, i_wr_data, i_wr_last, i_start, i_ready, i_loop,
      input  o_wr_ready, o_rows, o_sel, o_valid, o_done, o_count, o_busy, dbg_state
   );
   modport slave (
      input  i_wr_valid, i_wr_data, i_wr_last, i_start, i_ready, i_loop,
      output o_wr_ready, o_rows, o_sel, o_valid, o_done, o_count, o_busy, dbg_state
   );
`else
   modport master (
      output i_wr_valid, i_wr_data, i_wr_last, i_start, i_ready,
      input  o_wr_ready, o_rows, o_sel, o_valid, o_done, o_count, o_busy, dbg_state
   );
   modport slave (
      input  i_wr_valid, i_wr_data, i_wr_last, i_start, i_ready,
      output o_wr_ready, o_rows, o_sel, o_valid, o_done, o_count, o_busy, dbg_state
   );
`endif
endinterface

// File: rtl/row_seq_feeder.sv
// Buffers up to DEPTH rows, then steps a select index across them for the row mux.
// Define ROW_SEQ_LOOP_EN to add i_loop, which replays the loaded rows repeatedly.
module row_seq_feeder #(
   parameter int ROW   = 9,
   parameter int DEPTH = 10,
   parameter int SEL_W = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic             i_clk,
   input logic             i_rst,
   row_seq_feeder_if.slave bus
);
   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_FULL   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [ROW-1:0]   bank [DEPTH];
   logic [CNT_W-1:0] count;
   logic [SEL_W-1:0] sel;
   logic             done;
   logic             wr_fire;
   logic             wr_close;
   logic             beat_fire;
   logic             beat_last;
   logic             loop_on;

   assign wr_fire   = bus.i_wr_valid && (state == S_LOAD);
   assign wr_close  = bus.i_wr_last || (count == CNT_W'(DEPTH - 1));
   assign beat_fire = bus.i_ready && (state == S_STREAM);
   assign beat_last = (sel == SEL_W'(count - CNT_W'(1)));

`ifdef ROW_SEQ_LOOP_EN
   assign loop_on = bus.i_loop;
`else
   assign loop_on = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_LOAD;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_LOAD:   if (wr_fire && wr_close) state_nx = S_FULL;
         S_FULL:   if (bus.i_start) state_nx = S_STREAM;
         S_STREAM: if (beat_fire && beat_last && !loop_on) state_nx = S_LOAD;
         default:  state_nx = S_LOAD;
      endcase
   end

   // o_sel parks at all-ones outside streaming so the downstream mux outputs zero.
   always_comb begin
      bus.o_wr_ready = (state == S_LOAD);
      bus.o_valid    = (state == S_STREAM);
      bus.o_busy     = (state == S_FULL) || (state == S_STREAM);
      bus.o_sel      = sel;
      bus.o_done     = done;
      bus.o_count    = count;
      bus.dbg_state  = state;
   end

   always_comb begin
      bus.o_rows = '0;
      for (int k = 0; k < DEPTH; k++) bus.o_rows[ROW*k +: ROW] = bank[k];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
         count <= '0;
         sel   <= '1;
         done  <= 1'b0;
      end else begin
         done <= beat_fire && beat_last;
         if (wr_fire) begin
            bank[count] <= bus.i_wr_data;
            count       <= count + CNT_W'(1);
         end
         if ((state == S_FULL) && bus.i_start) sel <= '0;
         if (beat_fire) begin
            if (!beat_last) begin
               sel <= sel + SEL_W'(1);
            end else if (loop_on) begin
               sel <= '0;
            end else begin
               sel   <= '1;
               count <= '0;
               for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
            end
         end
      end
   end
endmodule
